// File: rtl/conv_pool_stage_pkg.sv
// Shared sizing for the convolver output stage: default parameters and
// the derived-geometry helpers used by the pooling stage and its siblings.
package conv_pool_stage_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_KERNEL_SIZE = 5;
   localparam int DEF_IMAGE_SIZE  = 28;

   // Edge of the valid-convolution map for a given image and kernel.
   function automatic int out_size(input int image_size, input int kernel_size);
      return image_size - kernel_size + 1;
   endfunction

   // Edge of the 2x2/stride-2 pooled map (odd trailing row/col dropped).
   function automatic int pool_size(input int image_size, input int kernel_size);
      return out_size(image_size, kernel_size) / 2;
   endfunction

   // Index width able to address n entries, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_pool_stage_line_buffer.sv
// Single-port line buffer holding one pooled row of partial horizontal maxima.
// Synchronous write, asynchronous read; contents are never reset because
// every entry is written on an even conv row before the odd row reads it.
module conv_pool_stage_line_buffer #(
   parameter int DEPTH      = 12,
   parameter int DATA_WIDTH = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store the horizontal max of an even-row block pair.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_pool_stage.sv
// Convolver output stage: tracks the streamed pixel position, keeps sums
// from fully populated kernel windows, applies ReLU and 2x2/stride-2 max
// pooling. Data is signed fixed point (8 fractional bits by default); the
// fraction position does not affect any arithmetic here.
module conv_pool_stage
   import conv_pool_stage_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] add_result,
   output logic [DATA_WIDTH-1:0] pool_out,
   output logic                  pool_valid,
   output logic                  pool_last,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int POOL_SIZE = pool_size(IMAGE_SIZE, KERNEL_SIZE);
   localparam int CW        = idx_width(IMAGE_SIZE);
   localparam int AW        = idx_width(POOL_SIZE);

   localparam logic [CW-1:0] LAST_IDX  = CW'(IMAGE_SIZE - 1);
   localparam logic [CW-1:0] WIN_START = CW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0] POOL_SPAN = CW'(2 * POOL_SIZE);
   localparam logic [CW-1:0] LAST_POS  = CW'(2 * POOL_SIZE - 1);

   // Position counters and their one-cycle-delayed copies (tags of add_result).
   logic [CW-1:0]         row_q, row_d, col_q, col_d;
   logic [CW-1:0]         row_tag_q, col_tag_q;
   logic                  v_q;
   logic                  err_q, err_d;
   // Pooling state and registered outputs.
   logic [DATA_WIDTH-1:0] hold_q, hold_d, out_q, out_d;
   logic                  valid_q, valid_d, last_q, last_d;
   // Combinational datapath.
   logic [CW-1:0]         r_s, c_s;
   logic                  win_s;
   logic [DATA_WIDTH-1:0] x_s, p_s, lb_rd_s;
   logic                  lb_we_s;
   logic [AW-1:0]         lb_addr_s;

   function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Raster position advance; a gap inside a frame freezes it and flags an error.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      err_d = err_q;
      if (in_valid) begin
         if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
               row_d = '0;
            end else begin
               row_d = row_q + CW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end else if ((row_q != '0) || (col_q != '0)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Window qualification, ReLU and the hold/line-buffer/output max selection.
   always_comb begin
      r_s       = row_tag_q - WIN_START;
      c_s       = col_tag_q - WIN_START;
      win_s     = v_q && (row_tag_q >= WIN_START) && (col_tag_q >= WIN_START) &&
                  (r_s < POOL_SPAN) && (c_s < POOL_SPAN);
      x_s       = add_result[DATA_WIDTH-1] ? '0 : add_result;
      p_s       = umax(hold_q, x_s);
      lb_addr_s = AW'(c_s >> 1);
      lb_we_s   = win_s && c_s[0] && !r_s[0];
      hold_d    = hold_q;
      out_d     = out_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      if (win_s && !c_s[0]) begin
         hold_d = x_s;
      end else if (win_s && r_s[0]) begin
         out_d   = umax(lb_rd_s, p_s);
         valid_d = 1'b1;
         last_d  = (r_s == LAST_POS) && (c_s == LAST_POS);
      end else begin
         hold_d = hold_q;
      end
   end

   // All stage state; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q     <= '0;
         col_q     <= '0;
         row_tag_q <= '0;
         col_tag_q <= '0;
         v_q       <= 1'b0;
         err_q     <= 1'b0;
         hold_q    <= '0;
         out_q     <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         row_q     <= row_d;
         col_q     <= col_d;
         row_tag_q <= row_q;
         col_tag_q <= col_q;
         v_q       <= in_valid;
         err_q     <= err_d;
         hold_q    <= hold_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
      end
   end

   conv_pool_stage_line_buffer #(
      .DEPTH      (POOL_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
   ) u_line_buffer (
      .clk     (clk),
      .we_i    (lb_we_s),
      .addr_i  (lb_addr_s),
      .wdata_i (p_s),
      .rdata_o (lb_rd_s)
   );

   assign pool_out   = out_q;
   assign pool_valid = valid_q;
   assign pool_last  = last_q;
   assign frame_done = last_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_conv_pool_stage.sv
// Directed bench for conv_pool_stage at default geometry (28x28 image, 5x5
// kernel -> 24x24 conv map -> 12x12 pooled map). Pixel m is presented in
// cycle m, its add_result in cycle m+1, and its pooled result is expected
// in cycle m+2 when it is the bottom-right of a 2x2 pool block.
module tb_conv_pool_stage;

   localparam int DW    = 16;
   localparam int IMG   = 28;
   localparam int K     = 5;
   localparam int PS    = 12;
   localparam int FRAME = IMG * IMG;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] add_result;
   logic [DW-1:0] pool_out;
   logic          pool_valid;
   logic          pool_last;
   logic          frame_done;
   logic          frame_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   conv_pool_stage dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .add_result (add_result),
      .pool_out   (pool_out),
      .pool_valid (pool_valid),
      .pool_last  (pool_last),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then move to 1 time unit after the next rising edge.
   task automatic tick(input logic v, input logic [DW-1:0] ar);
      in_valid   = v;
      add_result = ar;
      @(posedge clk);
      #1;
   endtask

   // Convolution sum the datapath would report for frame pixel q.
   function automatic logic [DW-1:0] conv_val(input int mode, input int q);
      int r;
      int c;
      r = q / IMG - (K - 1);
      c = q % IMG - (K - 1);
      case (mode)
         0:       return 16'h0100;
         1:       return 16'hFF00;
         default: return ((r >= 0) && (c >= 0)) ? DW'(24 * r + c) : 16'h0000;
      endcase
   endfunction

   // Stream nfr contiguous frames and check every output cycle.
   task automatic stream(input int nfr, input int mode, input string tag);
      int            total;
      int            p;
      int            q;
      int            r;
      int            c;
      int            pulses;
      int            first_cyc;
      int            first_done;
      int            last_done;
      logic          ev;
      logic          el;
      logic [DW-1:0] eo;
      total      = nfr * FRAME;
      pulses     = 0;
      first_cyc  = -1;
      first_done = -1;
      last_done  = -1;
      for (int m = 0; m < total + 2; m++) begin
         p = m - 1;
         tick((m < total), ((p >= 0) && (p < total)) ? conv_val(mode, p % FRAME) : 16'h0000);
         // now in cycle m+1: outputs belong to pixel m-1
         ev = 1'b0;
         el = 1'b0;
         eo = 16'h0000;
         if ((p >= 0) && (p < total)) begin
            q  = p % FRAME;
            r  = q / IMG - (K - 1);
            c  = q % IMG - (K - 1);
            ev = (r >= 0) && (c >= 0) && (r < 2 * PS) && (c < 2 * PS) &&
                 (r % 2 == 1) && (c % 2 == 1);
            el = ev && (r == 2 * PS - 1) && (c == 2 * PS - 1);
            eo = (mode == 0) ? 16'h0100 : (mode == 1) ? 16'h0000 : DW'(24 * r + c);
         end
         chk({tag, "_valid"}, 32'(pool_valid), 32'(ev));
         chk({tag, "_last"},  32'(pool_last),  32'(el));
         chk({tag, "_done"},  32'(frame_done), 32'(el));
         chk({tag, "_err"},   32'(frame_err),  32'h0);
         if (ev) begin
            chk({tag, "_data"}, 32'(pool_out), 32'(eo));
         end
         if (pool_valid === 1'b1) begin
            pulses++;
            if (first_cyc < 0) first_cyc = m + 1;
         end
         if (frame_done === 1'b1) begin
            if (first_done < 0) first_done = m + 1;
            last_done = m + 1;
         end
      end
      chk({tag, "_pulses"},     32'(pulses),    32'(144 * nfr));
      chk({tag, "_first_cyc"},  32'(first_cyc), 32'(147));
      chk({tag, "_last_cyc"},   32'(last_done), 32'(nfr * FRAME + 1));
      if (nfr > 1) begin
         chk({tag, "_done_gap"}, 32'(last_done - first_done), 32'((nfr - 1) * FRAME));
      end
   endtask

   initial begin
      reset      = 1'b0;
      in_valid   = 1'b0;
      add_result = 16'h0000;

      // 1: held in reset, inputs toggling, outputs stay cleared
      for (int i = 0; i < 8; i++) begin
         tick(((i % 2) == 1), DW'(i * 16'h1234));
         chk("t1_out",   32'(pool_out),   32'h0);
         chk("t1_valid", 32'(pool_valid), 32'h0);
         chk("t1_err",   32'(frame_err),  32'h0);
         chk("t1_done",  32'(frame_done), 32'h0);
      end
      reset = 1'b1;

      // 2: constant +1.0
      stream(1, 0, "t2");
      // 3: constant -1.0 clipped by ReLU
      stream(1, 1, "t3");
      // 4: position-coded sums, pool(i,j) = 24*(2i+1)+(2j+1)
      stream(1, 2, "t4");
      // 5: two frames back-to-back
      stream(2, 0, "t5");

      // 6: gap mid-frame, then reset mid-frame
      for (int m = 0; m < 300; m++) tick(1'b1, 16'h0100);
      for (int m = 0; m < 3; m++) begin
         tick(1'b0, 16'h0100);
         chk("t6_err_set", 32'(frame_err), 32'h1);
      end
      for (int m = 0; m < 100; m++) tick(1'b1, 16'h0100);
      chk("t6_err_sticky", 32'(frame_err), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("t6_rst_out",   32'(pool_out),   32'h0);
      chk("t6_rst_valid", 32'(pool_valid), 32'h0);
      chk("t6_rst_last",  32'(pool_last),  32'h0);
      chk("t6_rst_done",  32'(frame_done), 32'h0);
      chk("t6_rst_err",   32'(frame_err),  32'h0);
      tick(1'b0, 16'h0000);
      tick(1'b0, 16'h0000);
      reset = 1'b1;
      stream(1, 0, "t6_fresh");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
